svm_stage1_sequencer: RTL

- Sequences the stage-1 SVM kernel datapath: the bank of NUM_PE parallel dot-product MAC slices fed by per-PE support-vector BRAMs and one shared test-vector BRAM.
- For one test vector it walks every batch of NUM_PE support vectors pixel by pixel, issuing BRAM reads, MAC clear and accumulate enables, and a capture strobe per batch.
- Sits between the top-level start/done control and the RAM_fetch / dot_prod instances; replaces free-running enables with an explicit schedule.

---
 rtl/svm_stage1_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/svm_stage1_sequencer.sv
// rtl/svm_stage1_sequencer.sv - batch/pixel schedule for the stage-1 SVM kernel MAC bank
//
// Purpose: for one test vector, walks every batch of NUM_PE support vectors
// pixel by pixel. It issues BRAM reads and MAC clear/accumulate enables, and
// raises a capture strobe once per batch.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         begin one classification (sampled only in IDLE)
//   stall_MEM     freezes state, counters and read-latency delay line
//   sv_re/sv_addr       SV BRAM read enable / address (batch*NUM_OF_PIXELS+pixel)
//   test_re/test_addr   test-vector BRAM read enable / address (pixel)
//   mac_clr       clear all MAC accumulators
//   mac_en        accumulate enable, aligned to returning read data
//   kernel_valid  MAC outputs hold finished dot products for batch_id
//   batch_id      current batch index
//   pe_mask       PEs holding a real support vector in this batch
//   busy          sequencer not idle
//   done          one-cycle end-of-classification pulse
module svm_stage1_sequencer #(
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_OF_SV     = 100,
  parameter int NUM_PE        = 10,
  parameter int RD_LATENCY    = 1,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall_MEM,
  output logic              sv_re,
  output logic [ADDR_W-1:0] sv_addr,
  output logic              test_re,
  output logic [ADDR_W-1:0] test_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              kernel_valid,
  output logic [ADDR_W-1:0] batch_id,
  output logic [NUM_PE-1:0] pe_mask,
  output logic              busy,
  output logic              done
);

  localparam int NBATCH   = (NUM_OF_SV + NUM_PE - 1) / NUM_PE;
  localparam int LAST_CNT = NUM_OF_SV - (NBATCH - 1) * NUM_PE;
  localparam int PIX_W    = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam int BAT_W    = (NBATCH > 1) ? $clog2(NBATCH) : 1;
  // Linear SV address must reach NBATCH*NUM_OF_PIXELS-1 without wrapping.
  localparam int LIN_W    = $clog2(NBATCH * NUM_OF_PIXELS + 1);
  localparam int DRN_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [NUM_PE-1:0] FULL_MASK = '1;
  localparam logic [NUM_PE-1:0] LAST_MASK = FULL_MASK >> (NUM_PE - LAST_CNT);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(NUM_OF_PIXELS - 1);
  localparam logic [BAT_W-1:0]  BAT_LAST  = BAT_W'(NBATCH - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PIX_W-1:0]      pixel_q, pixel_d;
  logic [BAT_W-1:0]      batch_q, batch_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic [RD_LATENCY-1:0] dly_q, dly_d;
  logic [LIN_W-1:0]      lin_addr;
  logic                  issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pixel_q <= '0;
      batch_q <= '0;
      drain_q <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      pixel_q <= pixel_d;
      batch_q <= batch_d;
      drain_q <= drain_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pixel_d      = pixel_q;
    batch_d      = batch_q;
    drain_d      = drain_q;
    dly_d        = dly_q;
    issue        = 1'b0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    kernel_valid = 1'b0;
    done         = 1'b0;

    // A stall freezes everything, including the delay line, so in-flight
    // read slots resume exactly where they left off.
    if (!stall_MEM) begin
      issue  = (state_q == S_FETCH);
      // Shift the read-issue flag in at bit 0; the oldest slot falls off the top.
      dly_d  = RD_LATENCY'({dly_q, issue});
      mac_en = dly_q[RD_LATENCY-1];

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLEAR;
            batch_d = '0;
            pixel_d = '0;
          end
        end
        S_CLEAR: begin
          mac_clr = 1'b1;
          pixel_d = '0;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          // Pixel stays on the last index through DRAIN so addresses hold.
          if (pixel_q == PIX_LAST) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            pixel_d = pixel_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRN_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          kernel_valid = 1'b1;
          if (batch_q == BAT_LAST) begin
            state_d = S_DONE;
          end else begin
            batch_d = batch_q + 1'b1;
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
          batch_d = '0;
          pixel_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign lin_addr  = LIN_W'(batch_q) * LIN_W'(NUM_OF_PIXELS) + LIN_W'(pixel_q);
  assign sv_re     = issue;
  assign test_re   = issue;
  assign sv_addr   = ADDR_W'(lin_addr);
  assign test_addr = ADDR_W'(pixel_q);
  assign batch_id  = ADDR_W'(batch_q);
  assign busy      = (state_q != S_IDLE);
  assign pe_mask   = (state_q == S_IDLE) ? '0 :
                     (batch_q == BAT_LAST) ? LAST_MASK : FULL_MASK;

endmodule
